// File: rtl/aes_pkg.sv
// Shared AES datapath types and the ShiftRows byte-index helper.
// Byte k of a state sits at row k%4, column k/4.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int NB          = 4;
  localparam int BLOCK_BYTES = 16;

  // Source byte index feeding output index k. Inverse rotates each row right
  // by its row number, forward rotates it left; 2-bit column math wraps mod 4.
  function automatic logic [3:0] srow_idx(input logic [3:0] k, input logic inverse);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] src_c;
    r     = k[1:0];
    c     = k[3:2];
    src_c = inverse ? (c - r) : (c + r);
    return {src_c, r};
  endfunction

endpackage

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial (Inv)ShiftRows with two 16-byte ping-pong banks: one bank fills
// in arrival order while the other drains through the row-rotation index.
module inv_shift_rows_stream
  import aes_pkg::*;
#(
  parameter int BYTE_W  = 8,
  parameter bit INVERSE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_err
);

  logic [BYTE_W-1:0] bank_mem [2*BLOCK_BYTES];

  logic [1:0] bank_full_q, bank_full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic       frame_err_q, frame_err_d;

  logic       in_fire;
  logic       out_fire;
  logic [4:0] wr_addr;
  logic [4:0] rd_addr;

  assign in_ready  = !bank_full_q[wr_bank_q];
  assign out_valid = bank_full_q[rd_bank_q];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign wr_addr = {wr_bank_q, wr_cnt_q};
  assign rd_addr = {rd_bank_q, srow_idx(rd_cnt_q, INVERSE)};

  // Read is combinational so the byte is presented in the same cycle the
  // bank becomes full, and holds naturally while rd_cnt is stalled.
  assign out_data  = out_valid ? bank_mem[rd_addr] : '0;
  assign out_last  = out_valid && (rd_cnt_q == 4'hF);
  assign frame_err = frame_err_q;

  // Storage has no reset; bank_full gates every read of stale content.
  always_ff @(posedge clk) begin
    if (in_fire && !flush) begin
      bank_mem[wr_addr] <= in_data;
    end
  end

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_err_d = 1'b0;

    if (flush) begin
      bank_full_d = 2'b00;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      wr_cnt_d    = 4'd0;
      rd_cnt_d    = 4'd0;
    end else begin
      // Fill and drain always address different banks, so both may update.
      if (in_fire) begin
        wr_cnt_d    = wr_cnt_q + 4'd1;
        frame_err_d = (in_last != (wr_cnt_q == 4'hF));
        if (wr_cnt_q == 4'hF) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = !wr_bank_q;
        end
      end
      if (out_fire) begin
        rd_cnt_d = rd_cnt_q + 4'd1;
        if (rd_cnt_q == 4'hF) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = !rd_bank_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= 4'd0;
      rd_cnt_q    <= 4'd0;
      frame_err_q <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Bench for inv_shift_rows_stream: scoreboarded inverse instance plus a
// forward->inverse chain that must reproduce its input block.
module tb_inv_shift_rows_stream;
  import aes_pkg::*;

  typedef struct {
    byte_t din;
    byte_t inv_out;
    byte_t fwd_out;
  } vec_t;

  typedef struct {
    byte_t data;
    logic  last;
  } exp_t;

  logic  clk;
  logic  rst_n;
  logic  flush;
  logic  in_valid;
  logic  in_ready;
  byte_t in_data;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  byte_t out_data;
  logic  out_last;
  logic  frame_err;

  logic  f_flush, f_in_valid, f_in_ready, f_in_last, f_out_valid, f_out_last, f_frame_err;
  byte_t f_in_data, f_out_data;
  logic  c_in_ready, c_out_valid, c_out_ready, c_out_last, c_frame_err;
  byte_t c_out_data;

  inv_shift_rows_stream #(.BYTE_W(8), .INVERSE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_err(frame_err)
  );

  inv_shift_rows_stream #(.BYTE_W(8), .INVERSE(1'b0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .flush(f_flush),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data), .in_last(f_in_last),
    .out_valid(f_out_valid), .out_ready(c_in_ready), .out_data(f_out_data),
    .out_last(f_out_last), .frame_err(f_frame_err)
  );

  inv_shift_rows_stream #(.BYTE_W(8), .INVERSE(1'b1)) dut_chain (
    .clk(clk), .rst_n(rst_n), .flush(f_flush),
    .in_valid(f_out_valid), .in_ready(c_in_ready), .in_data(f_out_data), .in_last(f_out_last),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_last(c_out_last), .frame_err(c_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks;
  int    errors;
  vec_t  vecs [16];
  exp_t  q [$];
  byte_t blk [16];
  int    wcnt;
  logic  exp_fe;
  logic  stall_prev;
  byte_t prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wcnt       = 0;
    exp_fe     = 1'b0;
    stall_prev = 1'b0;
  endtask

  // One clock: drive inputs, check every output at the negedge, advance the model.
  task automatic step(input logic iv, input byte_t d, input logic il, input logic ordy,
                      input logic fl, output logic fired);
    logic exp_ir;
    logic have;
    in_valid  = iv;
    in_data   = d;
    in_last   = il;
    out_ready = ordy;
    flush     = fl;
    if (!rst_n) model_clear();
    @(negedge clk);
    have   = (q.size() != 0);
    exp_ir = (((q.size() + 15) / 16) < 2);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, have});
    chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
    if (have) begin
      chk("out_data", {24'd0, out_data}, {24'd0, q[0].data});
      chk("out_last", {31'd0, out_last}, {31'd0, q[0].last});
    end else begin
      chk("out_data_idle", {24'd0, out_data}, 32'd0);
      chk("out_last_idle", {31'd0, out_last}, 32'd0);
    end
    if (stall_prev && have) chk("stall_hold", {24'd0, out_data}, {24'd0, prev_data});
    fired      = iv && exp_ir && rst_n && !fl;
    stall_prev = have && !ordy;
    prev_data  = out_data;
    exp_fe     = 1'b0;
    if (!rst_n || fl) begin
      model_clear();
    end else begin
      if (have && ordy) void'(q.pop_front());
      if (fired) begin
        exp_fe    = (il != (wcnt == 15));
        blk[wcnt] = d;
        if (wcnt == 15) begin
          for (int j = 0; j < 16; j++) q.push_back('{blk[vecs[j].inv_out], (j == 15)});
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ordy_mode: 0 = never ready, 1 = always ready, 2 = random; held at 0 for `stall` cycles.
  task automatic send_bytes(input int n, input int base, input int last_pos,
                            input int ordy_mode, input int stall);
    int    sent;
    int    cyc;
    logic  fired;
    logic  ordy;
    byte_t b;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 4 * n + 200) begin
      if (cyc < stall || ordy_mode == 0) ordy = 1'b0;
      else if (ordy_mode == 1)           ordy = 1'b1;
      else                               ordy = 1'($urandom_range(0, 1));
      b = 8'(base + sent);
      step(1'b1, b, ((sent % 16) == last_pos), ordy, 1'b0, fired);
      if (fired) sent++;
      cyc++;
    end
    chk("send_timeout", sent, n);
  endtask

  task automatic drain(input int ordy_mode);
    int   cyc;
    logic fired;
    logic ordy;
    cyc = 0;
    while (q.size() != 0 && cyc < 400) begin
      ordy = (ordy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1'b0, 8'h00, 1'b0, ordy, 1'b0, fired);
      cyc++;
    end
    chk("drain_timeout", q.size(), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, fired);
  endtask

  initial begin
    byte_t inv_tab [16];
    byte_t fwd_tab [16];
    byte_t fwd_got [16];
    byte_t chain_got [16];
    int    nf;
    int    nc;
    int    cyc;
    logic  fired;

    inv_tab = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    fwd_tab = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    for (int k = 0; k < 16; k++) vecs[k] = '{8'(k), inv_tab[k], fwd_tab[k]};

    checks = 0;
    errors = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    out_ready = 1'b0;
    f_flush = 1'b0; f_in_valid = 1'b0; f_in_data = 8'h00; f_in_last = 1'b0; c_out_ready = 1'b1;
    model_clear();

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, fired);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, fired);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, fired);

    // Basic inverse block 00..0F
    send_bytes(16, 0, 15, 1, 0);
    drain(1);

    // Three blocks against a stalled sink, then release
    send_bytes(48, 8'h10, 15, 1, 40);
    drain(1);

    // Random back-pressure
    send_bytes(48, 8'h80, 15, 2, 0);
    drain(2);

    // in_last on byte 7 and missing on byte 15
    send_bytes(16, 8'h30, 7, 1, 0);
    drain(1);

    // Flush after 9 bytes; the flush-cycle byte is discarded
    send_bytes(9, 8'h50, 15, 1, 0);
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, fired);
    send_bytes(16, 0, 15, 1, 0);
    drain(1);

    // Reset mid-drain
    send_bytes(16, 8'h60, 15, 1, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, fired);
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, fired);
    rst_n = 1'b1;
    send_bytes(16, 0, 15, 1, 0);
    drain(1);

    // Forward instance alone, and forward chained into inverse
    nf  = 0;
    nc  = 0;
    cyc = 0;
    while ((nf < 16 || nc < 16) && cyc < 120) begin
      f_in_valid = (cyc < 16);
      f_in_data  = 8'(cyc);
      f_in_last  = (cyc == 15);
      @(negedge clk);
      if (cyc < 16) chk("fwd_in_ready", {31'd0, f_in_ready}, 32'd1);
      if (f_out_valid && c_in_ready && nf < 16) begin
        fwd_got[nf] = f_out_data;
        nf++;
      end
      if (c_out_valid && nc < 16) begin
        chain_got[nc] = c_out_data;
        chk("chain_last", {31'd0, c_out_last}, {31'd0, (nc == 15)});
        nc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    f_in_valid = 1'b0;
    chk("fwd_count", nf, 16);
    chk("chain_count", nc, 16);
    for (int k = 0; k < 16; k++) begin
      if (k < nf) chk("fwd_data", {24'd0, fwd_got[k]}, {24'd0, vecs[k].fwd_out});
      if (k < nc) chk("chain_data", {24'd0, chain_got[k]}, {24'd0, vecs[k].din});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
